// File: rtl/escalonador_fila_paradas.sv
// Stop-queue scheduler: collects origin/destination pairs from the switches
// into a circular queue and presents the next stop to the elevator control unit.
module escalonador_fila_paradas #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned ANDAR_W        = 4,
  parameter int unsigned TIMEOUT_CICLOS = 1023
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     novaEntrada,
  input  logic [ANDAR_W-1:0]       chaves,
  input  logic                     chegouDestino,
  output logic [ANDAR_W-1:0]       proxParada,
  output logic                     buscouPassageiro,
  output logic                     filaVazia,
  output logic                     filaCheia,
  output logic [$clog2(DEPTH):0]   ocupacao,
  output logic                     erroEntrada,
  output logic [1:0]               db_estado
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CICLOS + 1);

  typedef enum logic [1:0] {
    OCIOSO         = 2'b00,
    ESPERA_DESTINO = 2'b01,
    GRAVA          = 2'b10
  } estado_t;

  estado_t                estado_q, estado_d;
  logic [ANDAR_W-1:0]     origem_q, origem_d;
  logic [ANDAR_W-1:0]     destino_q, destino_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   erro_q, erro_d;
  logic [PTR_W-1:0]       wr_q, wr_d;
  logic [PTR_W-1:0]       rd_q, rd_d;
  logic [OCC_W-1:0]       ocup_q, ocup_d;
  logic                   buscou_q, buscou_d;
  logic [2*ANDAR_W-1:0]   mem_q [DEPTH];

  logic                   grava;
  logic                   pop;
  logic                   vazia;
  logic                   cheia;
  logic [2*ANDAR_W-1:0]   cabeca;

  assign vazia  = (ocup_q == '0);
  assign cheia  = (ocup_q == OCC_W'(DEPTH));
  assign cabeca = mem_q[rd_q];

  // Entry FSM: origin, then destination, then one commit cycle.
  always_comb begin
    estado_d  = estado_q;
    origem_d  = origem_q;
    destino_d = destino_q;
    cnt_d     = cnt_q;
    erro_d    = 1'b0;
    grava     = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (novaEntrada) begin
          if (chaves == '0) begin
            erro_d = 1'b1;
          end else begin
            origem_d = chaves;
            cnt_d    = '0;
            estado_d = ESPERA_DESTINO;
          end
        end
      end
      ESPERA_DESTINO: begin
        // A pulse on the final allowed cycle wins over the timeout.
        if (novaEntrada) begin
          if (chaves == '0 || chaves == origem_q || cheia) begin
            erro_d   = 1'b1;
            estado_d = OCIOSO;
          end else begin
            destino_d = chaves;
            estado_d  = GRAVA;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CICLOS - 1)) begin
          erro_d   = 1'b1;
          estado_d = OCIOSO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GRAVA: begin
        grava    = 1'b1;
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // Service side: first arrival picks the passenger up, second one drops and pops.
  always_comb begin
    pop      = chegouDestino && !vazia && buscou_q;
    buscou_d = buscou_q;
    if (chegouDestino && !vazia) begin
      buscou_d = !buscou_q;
    end
    rd_d   = pop   ? rd_q + PTR_W'(1) : rd_q;
    wr_d   = grava ? wr_q + PTR_W'(1) : wr_q;
    ocup_d = ocup_q + OCC_W'(grava) - OCC_W'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      origem_q  <= '0;
      destino_q <= '0;
      cnt_q     <= '0;
      erro_q    <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      ocup_q    <= '0;
      buscou_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      origem_q  <= origem_d;
      destino_q <= destino_d;
      cnt_q     <= cnt_d;
      erro_q    <= erro_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      ocup_q    <= ocup_d;
      buscou_q  <= buscou_d;
    end
  end

  always_ff @(posedge clock) begin
    if (grava) begin
      mem_q[wr_q] <= {origem_q, destino_q};
    end
  end

  always_comb begin
    proxParada = '0;
    if (!vazia) begin
      proxParada = buscou_q ? cabeca[ANDAR_W-1:0] : cabeca[2*ANDAR_W-1:ANDAR_W];
    end
  end

  assign buscouPassageiro = buscou_q;
  assign filaVazia        = vazia;
  assign filaCheia        = cheia;
  assign ocupacao         = ocup_q;
  assign erroEntrada      = erro_q;
  assign db_estado        = estado_q;

endmodule

// File: tb/tb_escalonador_fila_paradas.sv
// Bench for escalonador_fila_paradas: a queue-based reference model predicts
// every cycle's outputs into a scoreboard that a separate monitor drains.
module tb_escalonador_fila_paradas;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned T     = 1023;

  logic          clk = 1'b0;
  logic          rst;
  logic          nova;
  logic [AW-1:0] ch;
  logic          chegou;

  logic [AW-1:0] proxParada;
  logic          buscouPassageiro;
  logic          filaVazia;
  logic          filaCheia;
  logic [3:0]    ocupacao;
  logic          erroEntrada;
  logic [1:0]    db_estado;

  escalonador_fila_paradas #(
    .DEPTH(DEPTH),
    .ANDAR_W(AW),
    .TIMEOUT_CICLOS(T)
  ) dut (
    .clock(clk),
    .reset(rst),
    .novaEntrada(nova),
    .chaves(ch),
    .chegouDestino(chegou),
    .proxParada(proxParada),
    .buscouPassageiro(buscouPassageiro),
    .filaVazia(filaVazia),
    .filaCheia(filaCheia),
    .ocupacao(ocupacao),
    .erroEntrada(erroEntrada),
    .db_estado(db_estado)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] prox;
    logic          busc;
    logic          vazia;
    logic          cheia;
    logic [3:0]    ocup;
    logic          erro;
    logic [1:0]    est;
  } saida_t;

  saida_t sb[$];
  int     checks = 0;
  int     errors = 0;

  // Reference model: passenger queue plus the pending entry in progress.
  logic [AW-1:0] m_orig[$];
  logic [AW-1:0] m_dest[$];
  bit            m_buscou = 0;
  int            m_fase = 0;      // 0 nothing entered, 1 origin held, 2 pair accepted
  logic [AW-1:0] m_o, m_d;
  int            m_espera = 0;
  bit            m_erro = 0;
  int            m_n;
  bit            m_err_n, m_commit;
  saida_t        m_exp;
  int            ciclo = 0;

  always @(posedge clk) begin
    ciclo++;
    if (rst) begin
      m_orig.delete();
      m_dest.delete();
      m_buscou = 0;
      m_fase   = 0;
      m_erro   = 0;
      m_espera = 0;
    end else begin
      m_n      = m_orig.size();
      m_err_n  = 0;
      m_commit = (m_fase == 2);
      case (m_fase)
        0: if (nova) begin
             if (ch == 0) m_err_n = 1;
             else begin m_o = ch; m_espera = 0; m_fase = 1; end
           end
        1: if (nova) begin
             if (ch == 0 || ch == m_o || m_n == DEPTH) begin m_err_n = 1; m_fase = 0; end
             else begin m_d = ch; m_fase = 2; end
           end else begin
             m_espera++;
             if (m_espera == T) begin m_err_n = 1; m_fase = 0; end
           end
        default: m_fase = 0;
      endcase
      if (chegou && m_n > 0) begin
        if (m_buscou) begin
          void'(m_orig.pop_front());
          void'(m_dest.pop_front());
          m_buscou = 0;
        end else begin
          m_buscou = 1;
        end
      end
      if (m_commit) begin
        m_orig.push_back(m_o);
        m_dest.push_back(m_d);
      end
      m_erro = m_err_n;
    end
    m_exp.prox  = '0;
    if (m_orig.size() > 0) m_exp.prox = m_buscou ? m_dest[0] : m_orig[0];
    m_exp.busc  = m_buscou;
    m_exp.vazia = (m_orig.size() == 0);
    m_exp.cheia = (m_orig.size() == DEPTH);
    m_exp.ocup  = 4'(m_orig.size());
    m_exp.erro  = m_erro;
    m_exp.est   = 2'(m_fase);
    sb.push_back(m_exp);
  end

  saida_t mon_exp, mon_act;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_exp = sb.pop_front();
      mon_act = {proxParada, buscouPassageiro, filaVazia, filaCheia, ocupacao, erroEntrada, db_estado};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL saidas ciclo %0d: got prox=%0d busc=%0d vazia=%0d cheia=%0d ocup=%0d erro=%0d est=%0d, expected prox=%0d busc=%0d vazia=%0d cheia=%0d ocup=%0d erro=%0d est=%0d",
                 ciclo, mon_act.prox, mon_act.busc, mon_act.vazia, mon_act.cheia, mon_act.ocup, mon_act.erro, mon_act.est,
                 mon_exp.prox, mon_exp.busc, mon_exp.vazia, mon_exp.cheia, mon_exp.ocup, mon_exp.erro, mon_exp.est);
      end
    end
  end

  task automatic verifica(input string nome, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s ciclo %0d: got %0d, expected %0d", nome, ciclo, got, exp);
    end
  endtask

  task automatic cyc(input logic n, input logic [AW-1:0] c, input logic g);
    nova   = n;
    ch     = c;
    chegou = g;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, '0, 1'b0);
  endtask

  task automatic par(input logic [AW-1:0] o, input logic [AW-1:0] d);
    cyc(1'b1, o, 1'b0);
    idle(1);
    cyc(1'b1, d, 1'b0);
    idle(1);
  endtask

  task automatic chegadas(input int k);
    for (int i = 0; i < k; i++) begin
      cyc(1'b0, '0, 1'b1);
      idle(1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish, required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; nova = 1'b0; ch = '0; chegou = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset while waiting for a destination; the next pulse becomes an origin.
    cyc(1'b1, 4'd6, 1'b0);
    idle(3);
    rst = 1'b1; idle(2); rst = 1'b0;
    cyc(1'b1, 4'd9, 1'b0); idle(1); cyc(1'b1, 4'd2, 1'b0); idle(3);
    chegadas(2);

    // Normal pair, back-to-back pulses.
    cyc(1'b1, 4'd3, 1'b0); cyc(1'b1, 4'd7, 1'b0); idle(1);
    verifica("par ocupacao", 8'(ocupacao), 8'd1);
    verifica("par proxParada", 8'(proxParada), 8'd3);
    verifica("par buscouPassageiro", 8'(buscouPassageiro), 8'd0);
    idle(2);
    chegadas(2);
    verifica("par filaVazia", 8'(filaVazia), 8'd1);
    verifica("par proxParada vazia", 8'(proxParada), 8'd0);

    // Rejections and an arrival on an empty queue.
    cyc(1'b1, 4'd0, 1'b0);
    verifica("origem0 erroEntrada", 8'(erroEntrada), 8'd1);
    verifica("origem0 db_estado", 8'(db_estado), 8'd0);
    idle(2);
    cyc(1'b1, 4'd5, 1'b0); cyc(1'b1, 4'd5, 1'b0); idle(2);
    cyc(1'b0, '0, 1'b1); idle(2);

    // Fill, overflow attempt, partial drain, refill across the wrap, full drain.
    for (int i = 1; i <= 8; i++) par(AW'(i), AW'(i + 1));
    verifica("cheia filaCheia", 8'(filaCheia), 8'd1);
    verifica("cheia ocupacao", 8'(ocupacao), 8'd8);
    cyc(1'b1, 4'd1, 1'b0); cyc(1'b1, 4'd2, 1'b0);
    verifica("overflow erroEntrada", 8'(erroEntrada), 8'd1);
    idle(2);
    chegadas(6);
    par(4'd10, 4'd11); par(4'd12, 4'd13); par(4'd14, 4'd15);
    idle(2);
    chegadas(16);

    // Timeout expiry, then a destination on the last allowed cycle.
    cyc(1'b1, 4'd4, 1'b0); idle(T); idle(2);
    cyc(1'b1, 4'd4, 1'b0); idle(T - 1); cyc(1'b1, 4'd6, 1'b0); idle(3);
    chegadas(2);

    // Commit coinciding with the pop of the only stored pair.
    par(4'd1, 4'd2); idle(1);
    cyc(1'b0, '0, 1'b1); idle(1);
    cyc(1'b1, 4'd3, 1'b0); cyc(1'b1, 4'd5, 1'b0); cyc(1'b0, '0, 1'b1); idle(3);
    chegadas(2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      cyc($urandom_range(0, 99) < 30, AW'($urandom_range(0, 15)), $urandom_range(0, 99) < 25);
    end
    rst = 1'b0;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
